// File: rtl/calc_op_sequencer_if.sv
// Button/switch inputs and result/func/LED outputs of the calculator front-end.
interface calc_op_sequencer_if;
  logic        btn_clear;
  logic        btn_load_a;
  logic        btn_load_b;
  logic        btn_op;
  logic        btn_exec;
  logic [7:0]  sw;
  logic [13:0] result;
  logic [2:0]  func;
  logic [7:0]  led;

  modport master (
    output btn_clear, btn_load_a, btn_load_b, btn_op, btn_exec, sw,
    input  result, func, led
  );

  modport slave (
    input  btn_clear, btn_load_a, btn_load_b, btn_op, btn_exec, sw,
    output result, func, led
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// Calculator front-end: debounced buttons, operand latches, ADD/SUB in 1 cycle, MUL/DIV in 8.
// Result lands 2 cycles (ADD/SUB) or 9 cycles (MUL/DIV) after the accepted exec pulse.
module calc_op_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W            = 16
) (
  input logic               clock,
  input logic               reset_n,
  calc_op_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE, ERR} state_t;

  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  // Button index order doubles as priority order: clear, exec, load_a, load_b, op.
  logic [4:0]      raw, sync1, sync2, lvl, pulse;
  logic [DB_W-1:0] db_cnt [5];

  assign raw = {bus.btn_op, bus.btn_load_b, bus.btn_load_a, bus.btn_exec, bus.btn_clear};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          lvl[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pulse fires in the same cycle the new high level is accepted.
  always_comb begin
    pulse = '0;
    for (int i = 0; i < 5; i++) pulse[i] = sync2[i] & ~lvl[i] & (db_cnt[i] == DB_MAX);
  end

  logic win_clear, win_exec, win_load_a, win_load_b, win_op;
  assign win_clear  = pulse[0];
  assign win_exec   = pulse[1] & ~pulse[0];
  assign win_load_a = pulse[2] & ~|pulse[1:0];
  assign win_load_b = pulse[3] & ~|pulse[2:0];
  assign win_op     = pulse[4] & ~|pulse[3:0];

  state_t      state, state_nxt;
  logic [7:0]  op_a, op_b, op_a_nxt, op_b_nxt;
  logic [1:0]  op_sel, op_sel_nxt;
  logic [13:0] res_q, res_nxt;
  logic        neg_q, neg_nxt, err_q, err_nxt;
  logic [2:0]  iter, iter_nxt;
  logic [15:0] acc, acc_nxt;
  logic [7:0]  quo, quo_nxt;

  // Shared 16-bit adder/subtractor; bit 16 is the carry/borrow.
  logic        a_lt_b, alu_sub, div_ok, mul_ovf, last_step;
  logic [15:0] alu_x, alu_y, rem_nxt;
  logic [16:0] alu_out;
  logic [7:0]  quo_shift;
  logic [13:0] fin_res;
  logic        fin_neg, fin_err;

  assign a_lt_b = op_a < op_b;

  always_comb begin
    alu_x   = '0;
    alu_y   = '0;
    alu_sub = 1'b0;
    case (op_sel)
      2'd0: begin
        alu_x = {8'd0, op_a};
        alu_y = {8'd0, op_b};
      end
      2'd1: begin
        alu_sub = 1'b1;
        alu_x   = a_lt_b ? {8'd0, op_b} : {8'd0, op_a};
        alu_y   = a_lt_b ? {8'd0, op_a} : {8'd0, op_b};
      end
      2'd2: begin
        alu_x = acc;
        alu_y = op_b[iter] ? ({8'd0, op_a} << iter) : 16'd0;
      end
      default: begin
        // Restoring division: shift next dividend bit (MSB first) into the remainder.
        alu_sub = 1'b1;
        alu_x   = {acc[14:0], op_a[3'd7 - iter]};
        alu_y   = {8'd0, op_b};
      end
    endcase
    alu_out = alu_sub ? ({1'b0, alu_x} - {1'b0, alu_y}) : ({1'b0, alu_x} + {1'b0, alu_y});
  end

  assign div_ok    = ~alu_out[16];
  assign rem_nxt   = div_ok ? alu_out[15:0] : alu_x;
  assign quo_shift = {quo[6:0], div_ok};
  assign mul_ovf   = alu_out[15:0] > 16'd9999;
  assign last_step = ~op_sel[1] | (iter == 3'd7);

  always_comb begin
    fin_res = alu_out[13:0];
    fin_neg = 1'b0;
    fin_err = 1'b0;
    case (op_sel)
      2'd1: fin_neg = a_lt_b;
      2'd2: begin
        fin_err = mul_ovf;
        if (mul_ovf) fin_res = 14'd9999;
      end
      2'd3: fin_res = {6'd0, quo_shift};
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    op_a_nxt   = op_a;
    op_b_nxt   = op_b;
    op_sel_nxt = op_sel;
    res_nxt    = res_q;
    neg_nxt    = neg_q;
    err_nxt    = err_q;
    iter_nxt   = iter;
    acc_nxt    = acc;
    quo_nxt    = quo;
    if (win_clear) begin
      state_nxt  = IDLE;
      op_a_nxt   = '0;
      op_b_nxt   = '0;
      op_sel_nxt = 2'd0;
      res_nxt    = '0;
      neg_nxt    = 1'b0;
      err_nxt    = 1'b0;
    end else if (state == EXEC) begin
      iter_nxt = iter + 3'd1;
      acc_nxt  = (op_sel == 2'd3) ? rem_nxt : alu_out[15:0];
      quo_nxt  = quo_shift;
      if (last_step) begin
        res_nxt   = fin_res;
        neg_nxt   = fin_neg;
        err_nxt   = fin_err;
        state_nxt = DONE;
      end
    end else if (win_exec) begin
      neg_nxt = 1'b0;
      err_nxt = 1'b0;
      if (op_sel == 2'd3 && op_b == 8'd0) begin
        state_nxt = ERR;
        res_nxt   = '0;
        err_nxt   = 1'b1;
      end else begin
        state_nxt = EXEC;
        iter_nxt  = '0;
        acc_nxt   = '0;
        quo_nxt   = '0;
      end
    end else if (win_load_a) begin
      op_a_nxt  = bus.sw;
      state_nxt = IDLE;
    end else if (win_load_b) begin
      op_b_nxt  = bus.sw;
      state_nxt = IDLE;
    end else if (win_op) begin
      op_sel_nxt = op_sel + 2'd1;
      state_nxt  = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= 2'd0;
      res_q  <= '0;
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
      iter   <= '0;
      acc    <= '0;
      quo    <= '0;
    end else begin
      state  <= state_nxt;
      op_a   <= op_a_nxt;
      op_b   <= op_b_nxt;
      op_sel <= op_sel_nxt;
      res_q  <= res_nxt;
      neg_q  <= neg_nxt;
      err_q  <= err_nxt;
      iter   <= iter_nxt;
      acc    <= acc_nxt;
      quo    <= quo_nxt;
    end
  end

  assign bus.result = res_q;
  assign bus.func   = {neg_q, op_sel};
  assign bus.led    = {neg_q, err_q, state == DONE, state == EXEC, 4'b0001 << op_sel};
endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: vector table, timing sequences, random run against a model.
module tb_calc_op_sequencer;
  localparam logic [4:0] CLR = 5'b00001, EXE = 5'b00010, LDA = 5'b00100,
                         LDB = 5'b01000, OPB = 5'b10000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  calc_op_sequencer_if bus();
  calc_op_sequencer #(.DEBOUNCE_CYCLES(4), .DB_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (spec-level: operands, op, result and flags).
  int ma, mb, mop, mres;
  bit mneg, merr, mdone;

  typedef struct {
    logic [4:0]  mask;
    logic [7:0]  swv;
    logic [13:0] res;
    logic [2:0]  fn;
    logic [7:0]  ld;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_btns(input logic [4:0] m);
    bus.btn_clear  = m[0];
    bus.btn_exec   = m[1];
    bus.btn_load_a = m[2];
    bus.btn_load_b = m[3];
    bus.btn_op     = m[4];
  endtask

  // Hold the buttons for 4 cycles, then give debounce and MUL/DIV time to settle.
  task automatic press(input logic [4:0] m, input logic [7:0] v);
    bus.sw = v;
    for (int c = 0; c < 16; c++) begin
      set_btns(c < 4 ? m : 5'd0);
      tick();
    end
  endtask

  function automatic void model_reset();
    ma = 0; mb = 0; mop = 0; mres = 0; mneg = 0; merr = 0; mdone = 0;
  endfunction

  function automatic void model_pulse(input logic [4:0] m, input int v);
    int p;
    if (m[0]) model_reset();
    else if (m[1]) begin
      mneg = 0; merr = 0;
      if (mop == 3 && mb == 0) begin
        mres = 0; merr = 1; mdone = 0;
      end else begin
        mdone = 1;
        case (mop)
          0: mres = ma + mb;
          1: begin mres = (ma >= mb) ? ma - mb : mb - ma; mneg = (ma < mb); end
          2: begin
            p = ma * mb;
            if (p > 9999) begin mres = 9999; merr = 1; end else mres = p;
          end
          default: mres = ma / mb;
        endcase
      end
    end
    else if (m[2]) begin ma = v; mdone = 0; end
    else if (m[3]) begin mb = v; mdone = 0; end
    else if (m[4]) begin mop = (mop + 1) % 4; mdone = 0; end
  endfunction

  function automatic int model_led();
    return (1 << mop) | (int'(mdone) << 5) | (int'(merr) << 6) | (int'(mneg) << 7);
  endfunction

  task automatic check_model(input string name);
    check({name, "_res"},  bus.result, mres);
    check({name, "_func"}, bus.func, (int'(mneg) << 2) | mop);
    check({name, "_led"},  bus.led, model_led());
  endtask

  function automatic void add(input logic [4:0] m, input logic [7:0] s, input logic [13:0] r,
                              input logic [2:0] f, input logic [7:0] l);
    vec_t t;
    t.mask = m; t.swv = s; t.res = r; t.fn = f; t.ld = l;
    tbl.push_back(t);
  endfunction

  initial begin
    add(LDA, 200, 0, 3'b000, 8'h01);  add(LDB, 55, 0, 3'b000, 8'h01);
    add(EXE, 0, 255, 3'b000, 8'h21);  add(OPB, 0, 255, 3'b001, 8'h02);
    add(LDA, 5, 255, 3'b001, 8'h02);  add(LDB, 9, 255, 3'b001, 8'h02);
    add(EXE, 0, 4, 3'b101, 8'hA2);    add(OPB, 0, 4, 3'b110, 8'h84);
    add(LDA, 99, 4, 3'b110, 8'h84);   add(LDB, 99, 4, 3'b110, 8'h84);
    add(EXE, 0, 9801, 3'b010, 8'h24); add(LDA, 255, 9801, 3'b010, 8'h04);
    add(LDB, 255, 9801, 3'b010, 8'h04); add(EXE, 0, 9999, 3'b010, 8'h64);
    add(OPB, 0, 9999, 3'b011, 8'h48); add(LDA, 200, 9999, 3'b011, 8'h48);
    add(LDB, 7, 9999, 3'b011, 8'h48); add(EXE, 0, 28, 3'b011, 8'h28);
    add(LDB, 0, 28, 3'b011, 8'h08);   add(EXE, 0, 0, 3'b011, 8'h48);
    add(LDB, 3, 0, 3'b011, 8'h48);    add(EXE, 0, 66, 3'b011, 8'h28);
    add(OPB, 0, 66, 3'b000, 8'h01);   add(CLR, 0, 0, 3'b000, 8'h01);
    add(OPB, 0, 0, 3'b001, 8'h02);    add(OPB, 0, 0, 3'b010, 8'h04);
    add(OPB, 0, 0, 3'b011, 8'h08);    add(OPB, 0, 0, 3'b000, 8'h01);
    add(OPB, 0, 0, 3'b001, 8'h02);    add(CLR, 0, 0, 3'b000, 8'h01);

    set_btns(5'd0);
    bus.sw = 8'd0;
    model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("reset_res", bus.result, 0);
    check("reset_func", bus.func, 0);
    check("reset_led", bus.led, 8'h01);

    foreach (tbl[i]) begin
      press(tbl[i].mask, tbl[i].swv);
      model_pulse(tbl[i].mask, tbl[i].swv);
      check($sformatf("vec%0d_res", i), bus.result, tbl[i].res);
      check($sformatf("vec%0d_func", i), bus.func, tbl[i].fn);
      check($sformatf("vec%0d_led", i), bus.led, tbl[i].ld);
    end

    // Glitch shorter than the debounce window must not latch.
    bus.sw = 8'd7;
    for (int c = 0; c < 19; c++) begin
      set_btns(c < 3 ? LDA : 5'd0);
      tick();
    end
    press(EXE, 0);
    model_pulse(EXE, 0);
    check("glitch_ignored", bus.result, 0);
    // Long hold latches once; sw changes after acceptance must not be picked up.
    for (int c = 0; c < 22; c++) begin
      bus.sw = (c < 7) ? 8'd7 : 8'd9;
      set_btns(c < 10 ? LDA : 5'd0);
      tick();
    end
    model_pulse(LDA, 7);
    press(EXE, 0);
    model_pulse(EXE, 0);
    check("single_latch", bus.result, 7);

    // ADD: pulse in cycle 5, busy in 6, done and result in 7.
    press(LDA, 200); model_pulse(LDA, 200);
    press(LDB, 55);  model_pulse(LDB, 55);
    bus.sw = 8'd0;
    for (int c = 0; c < 16; c++) begin
      set_btns(c < 4 ? EXE : 5'd0);
      if (c == 6) begin
        check("add_busy", bus.led[5:4], 2'b01);
        check("add_no_early_res", bus.result, 7);
      end
      if (c == 7) begin
        check("add_done", bus.led[5:4], 2'b10);
        check("add_res", bus.result, 255);
        check("add_func", bus.func, 0);
      end
      tick();
    end
    model_pulse(EXE, 0);

    // MUL: busy cycles 6..13, done in 14; second exec pulse lands in cycle 13 and is dropped.
    press(OPB, 0); model_pulse(OPB, 0);
    press(OPB, 0); model_pulse(OPB, 0);
    press(LDA, 99); model_pulse(LDA, 99);
    press(LDB, 99); model_pulse(LDB, 99);
    for (int c = 0; c < 24; c++) begin
      set_btns((c < 4 || (c >= 8 && c < 12)) ? EXE : 5'd0);
      if (c >= 6 && c <= 13) check($sformatf("mul_busy_c%0d", c), bus.led[5:4], 2'b01);
      if (c == 13) check("mul_no_early_res", bus.result, 255);
      if (c == 14) begin
        check("mul_done", bus.led[5:4], 2'b10);
        check("mul_res", bus.result, 9801);
      end
      if (c == 20) check("mul_exec_dropped", bus.led[5:4], 2'b10);
      tick();
    end
    model_pulse(EXE, 0);

    // Clear pulse at N+4 aborts a running MUL.
    for (int c = 0; c < 20; c++) begin
      set_btns((c < 4 ? EXE : 5'd0) | ((c >= 4 && c < 8) ? CLR : 5'd0));
      if (c == 9) check("abort_busy", bus.led[4], 1);
      if (c == 10) begin
        check("abort_res", bus.result, 0);
        check("abort_led", bus.led, 8'h01);
      end
      if (c == 15) check("abort_no_done", bus.led[5], 0);
      tick();
    end
    model_pulse(EXE, 0);
    model_pulse(CLR, 0);
    check_model("abort");

    // Asynchronous reset in the middle of a DIV.
    for (int i = 0; i < 3; i++) begin press(OPB, 0); model_pulse(OPB, 0); end
    press(LDA, 200); model_pulse(LDA, 200);
    press(LDB, 7);   model_pulse(LDB, 7);
    for (int c = 0; c < 10; c++) begin
      set_btns(c < 4 ? EXE : 5'd0);
      if (c == 8) check("div_busy", bus.led[4], 1);
      if (c == 9) begin
        #2 reset_n = 1'b0;
        #1;
        check("arst_res", bus.result, 0);
        check("arst_func", bus.func, 0);
        check("arst_led", bus.led, 8'h01);
      end
      else tick();
    end
    tick();
    #3 reset_n = 1'b1;
    model_reset();
    repeat (14) tick();
    check_model("after_arst");

    // Simultaneous clear and exec: clear wins.
    press(LDA, 12); model_pulse(LDA, 12);
    press(LDB, 30); model_pulse(LDB, 30);
    press(CLR | EXE, 0);
    model_pulse(CLR | EXE, 0);
    check("clr_exec_done", bus.led[5], 0);
    check_model("clr_exec");

    for (int i = 0; i < 60; i++) begin
      logic [4:0] m;
      logic [7:0] v;
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0)       m = CLR;
      else if (r < 6)   m = EXE;
      else if (r < 10)  m = LDA;
      else if (r < 14)  m = LDB;
      else if (r < 18)  m = OPB;
      else              m = 5'($urandom_range(1, 31));
      v = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      press(m, v);
      model_pulse(m, v);
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
